// File: rtl/vector_load_store_unit.sv
// vector_load_store_unit: moves one LANES x WIDTH vector between a
// word-addressed synchronous data memory and the vector register bank.
//
// Ports:
//   CLK, RST         clock (rising edge), async active-high reset
//   START, OP        transfer request (sampled in IDLE); 0 = load, 1 = store
//   BASE_ADDR        word address of lane 0 (wraps modulo 2^ADDR_W)
//   VS               store source vector, latched at START
//   MEM_RD           memory read data, valid one cycle after MEM_ADDR
//   MEM_ADDR/WE/WD   registered memory address, write enable, write data
//   VD_OUT, WE3      assembled load vector and 1-cycle bank write enable
//   BUSY, DONE       transfer in progress, 1-cycle completion pulse
module vector_load_store_unit #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 10,
    parameter int ADDR_W = 16
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         OP,
    input  logic [ADDR_W-1:0]            BASE_ADDR,
    input  logic [LANES-1:0][WIDTH-1:0]  VS,
    input  logic [WIDTH-1:0]             MEM_RD,
    output logic [ADDR_W-1:0]            MEM_ADDR,
    output logic                         MEM_WE,
    output logic [WIDTH-1:0]             MEM_WD,
    output logic [LANES-1:0][WIDTH-1:0]  VD_OUT,
    output logic                         WE3,
    output logic                         BUSY,
    output logic                         DONE
);

    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_LAST,
        S_WRITEBACK,
        S_STORE,
        S_FINISH
    } state_t;

    state_t                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic [ADDR_W-1:0]             r_base;
    logic [LANES-1:0][WIDTH-1:0]   r_vs;
    // Lanes 0..LANES-2 only; the last lane goes straight from MEM_RD
    // into VD_OUT on entry to WRITEBACK.
    logic [LANES-2:0][WIDTH-1:0]   r_buf;
    logic [LANES-1:0][WIDTH-1:0]   r_vd;
    logic [ADDR_W-1:0]             r_addr;
    logic                          r_we;
    logic [WIDTH-1:0]              r_wd;
    logic                          r_we3;
    logic                          r_done;
    logic                          r_busy;

    state_t                        w_state;
    logic [CNT_W-1:0]              w_cnt;
    logic [CNT_W-1:0]              w_cnt_inc;
    logic [ADDR_W-1:0]             w_base;
    logic [ADDR_W-1:0]             w_addr;
    logic [ADDR_W-1:0]             w_addr_inc;
    logic                          w_we;
    logic [WIDTH-1:0]              w_wd;
    logic                          w_we3;
    logic                          w_done;
    logic                          w_busy;
    logic                          w_last;
    logic                          w_accept;

    assign w_last     = (r_cnt == CNT_W'(LANES - 1));
    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_addr_inc = r_base + ADDR_W'(r_cnt) + ADDR_W'(1);
    assign w_accept   = (r_state == S_IDLE) && START;

    // Next-state and next-output logic; every output is registered, so
    // the value computed here appears on the port during the next state.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_base  = r_base;
        w_addr  = r_addr;
        w_we    = 1'b0;
        w_wd    = r_wd;
        w_we3   = 1'b0;
        w_done  = 1'b0;
        w_busy  = r_busy;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (START) begin
                    w_base = BASE_ADDR;
                    w_addr = BASE_ADDR;
                    w_cnt  = '0;
                    w_busy = 1'b1;
                    if (OP) begin
                        w_state = S_STORE;
                        w_we    = 1'b1;
                        w_wd    = VS[0];
                    end else begin
                        w_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (w_last) begin
                    w_state = S_LOAD_LAST;
                end else begin
                    w_cnt  = w_cnt_inc;
                    w_addr = w_addr_inc;
                end
            end
            S_LOAD_LAST: begin
                w_state = S_WRITEBACK;
                w_we3   = 1'b1;
                w_done  = 1'b1;
            end
            S_WRITEBACK: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            S_STORE: begin
                if (w_last) begin
                    w_state = S_FINISH;
                    w_done  = 1'b1;
                end else begin
                    w_cnt  = w_cnt_inc;
                    w_addr = w_addr_inc;
                    w_we   = 1'b1;
                    w_wd   = r_vs[w_cnt_inc];
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wd    <= '0;
            r_we3   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_base  <= w_base;
            r_addr  <= w_addr;
            r_we    <= w_we;
            r_wd    <= w_wd;
            r_we3   <= w_we3;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    // Read data lags the address by one cycle, so LOAD step i captures
    // the word requested in step i-1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vs  <= '0;
            r_buf <= '0;
            r_vd  <= '0;
        end else begin
            if (w_accept && OP) begin
                r_vs <= VS;
            end
            if (r_state == S_LOAD && r_cnt != '0) begin
                r_buf[r_cnt - 1'b1] <= MEM_RD;
            end
            if (r_state == S_LOAD_LAST) begin
                r_vd <= {MEM_RD, r_buf};
            end
        end
    end

    assign MEM_ADDR = r_addr;
    assign MEM_WE   = r_we;
    assign MEM_WD   = r_wd;
    assign VD_OUT   = r_vd;
    assign WE3      = r_we3;
    assign BUSY     = r_busy;
    assign DONE     = r_done;

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Self-checking bench for vector_load_store_unit: directed and random
// loads/stores against a word-array memory reference model.
module tb_vector_load_store_unit;

    localparam int WIDTH  = 16;
    localparam int LANES  = 10;
    localparam int ADDR_W = 16;
    localparam int VW     = LANES * WIDTH;

    typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

    logic              CLK;
    logic              RST;
    logic              START;
    logic              OP;
    logic [ADDR_W-1:0] BASE_ADDR;
    vec_t              VS;
    logic [WIDTH-1:0]  MEM_RD;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_WE;
    logic [WIDTH-1:0]  MEM_WD;
    vec_t              VD_OUT;
    logic              WE3;
    logic              BUSY;
    logic              DONE;

    logic [WIDTH-1:0] mem     [0:65535];
    logic [WIDTH-1:0] ref_mem [0:65535];
    vec_t             last_vd;
    int               n_checks;
    int               n_errors;

    vector_load_store_unit #(
        .WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .BASE_ADDR(BASE_ADDR), .VS(VS), .MEM_RD(MEM_RD),
        .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WD(MEM_WD),
        .VD_OUT(VD_OUT), .WE3(WE3), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // Synchronous memory: read data valid one cycle after the address.
    always @(posedge CLK) begin
        MEM_RD <= mem[MEM_ADDR];
        if (MEM_WE) mem[MEM_ADDR] <= MEM_WD;
    end

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        for (int k = 0; k < LANES; k++) v[k] = WIDTH'($urandom);
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk(tag, VW'({MEM_ADDR, MEM_WE, MEM_WD, WE3, BUSY, DONE}), '0);
        chk({tag, "_vd"}, VD_OUT, '0);
    endtask

    // One transfer. hold: keep START high through it (and leave it high).
    // pre: START was already presented and is accepted at the next edge.
    // pulse: re-assert START mid-transfer.
    task automatic xfer(input bit op, input logic [ADDR_W-1:0] base,
                        input vec_t vs, input bit hold, input bit pre,
                        input bit pulse);
        vec_t              exp_vec;
        logic [ADDR_W-1:0] a;
        int                done_n, we_cnt, we3_cnt, busy_lo, vd_bad;
        done_n = 0; we_cnt = 0; we3_cnt = 0; busy_lo = 0; vd_bad = 0;
        for (int k = 0; k < LANES; k++) begin
            a = base + ADDR_W'(k);
            exp_vec[k] = ref_mem[a];
        end
        if (!pre) begin
            @(negedge CLK);
            START = 1'b1; OP = op; BASE_ADDR = base; VS = vs;
        end
        @(posedge CLK); #1;
        if (!hold) begin
            START = 1'b0;
            BASE_ADDR = ADDR_W'($urandom);
            VS = rand_vec();
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (n <= LANES) begin
                a = base + ADDR_W'(n - 1);
                chk("addr", VW'(MEM_ADDR), VW'(a));
                if (op) chk("wdata", VW'(MEM_WD), VW'(vs[n-1]));
            end
            if (MEM_WE) we_cnt++;
            if (WE3) we3_cnt++;
            if (!BUSY) busy_lo++;
            if (DONE) begin
                done_n = n;
                break;
            end
            if (VD_OUT !== last_vd) vd_bad++;
            if (!hold && op) VS = rand_vec();
            if (pulse && n == 5) START = 1'b1;
            if (pulse && n == 6) START = 1'b0;
        end
        chk("done_latency", VW'(done_n), VW'(op ? LANES + 1 : LANES + 2));
        chk("mem_we_cycles", VW'(we_cnt), VW'(op ? LANES : 0));
        chk("we3_cycles", VW'(we3_cnt), VW'(op ? 0 : 1));
        chk("busy_low", VW'(busy_lo), '0);
        chk("vd_early_change", VW'(vd_bad), '0);
        if (!op) last_vd = exp_vec;
        else begin
            for (int k = 0; k < LANES; k++) begin
                a = base + ADDR_W'(k);
                ref_mem[a] = vs[k];
            end
        end
        chk("vd_out", VD_OUT, last_vd);
        @(negedge CLK);
        chk("after_done", VW'({BUSY, DONE, WE3, MEM_WE}), '0);
        chk("vd_hold", VD_OUT, last_vd);
    endtask

    initial begin
        vec_t              v;
        logic [ADDR_W-1:0] b;
        bit                o;
        n_checks = 0; n_errors = 0;
        CLK = 1'b0; RST = 1'b1; START = 1'b0; OP = 1'b0;
        BASE_ADDR = '0; VS = '0; MEM_RD = '0; last_vd = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = WIDTH'($urandom);
            ref_mem[i] = mem[i];
        end

        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk_zero("idle");
        end

        for (int k = 0; k < LANES; k++) begin
            mem[100+k] = WIDTH'(11 * k);
            ref_mem[100+k] = WIDTH'(11 * k);
        end
        xfer(1'b0, 16'd100, '0, 1'b0, 1'b0, 1'b0);
        chk("load_plan", VD_OUT,
            {16'd99, 16'd88, 16'd77, 16'd66, 16'd55,
             16'd44, 16'd33, 16'd22, 16'd11, 16'd0});

        for (int k = 0; k < LANES; k++) v[k] = WIDTH'(16'h0101 * k);
        xfer(1'b1, 16'h0200, v, 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'h0200, '0, 1'b0, 1'b0, 1'b0);

        xfer(1'b0, 16'hFFFC, '0, 1'b0, 1'b0, 1'b0);
        xfer(1'b1, 16'hFFFE, rand_vec(), 1'b0, 1'b0, 1'b0);
        xfer(1'b0, 16'hFFFE, '0, 1'b0, 1'b0, 1'b0);

        xfer(1'b0, 16'd300, '0, 1'b1, 1'b0, 1'b0);
        xfer(1'b0, 16'd300, '0, 1'b0, 1'b1, 1'b0);
        xfer(1'b0, 16'd500, '0, 1'b0, 1'b0, 1'b1);

        @(negedge CLK);
        START = 1'b1; OP = 1'b0; BASE_ADDR = 16'd700;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b1;
        #1;
        chk_zero("mid_reset");
        last_vd = '0;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            chk_zero("post_reset");
        end
        xfer(1'b0, 16'd700, '0, 1'b0, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            o = 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) == 0)
                ? ADDR_W'(16'hFFF8 + $urandom_range(0, 7))
                : ADDR_W'($urandom);
            xfer(o, b, rand_vec(), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vector_load_store_unit.md
Name: vector_load_store_unit

Overview:
- Memory-side stage upstream/downstream of the vector register bank (10 lanes x 16 bit).
- Load: fetches LANES consecutive words from a word-addressed synchronous data memory, assembles them into one vector and issues a single-cycle write enable to the bank's write port.
- Store: takes the bank's read vector and writes it to LANES consecutive memory words.
- One transfer in flight at a time; start/busy/done handshake to the control unit.

Parameters:
- WIDTH, 16, bits per lane element.
- LANES, 10, number of vector lanes and words per transfer.
- ADDR_W, 16, memory word-address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request a transfer; sampled only in IDLE.
- OP  in  1  0 = load (memory -> bank), 1 = store (bank -> memory).
- BASE_ADDR  in  ADDR_W  word address of lane 0.
- VS  in  [LANES-1:0][WIDTH-1:0]  store source vector, from bank read port VD1.
- MEM_RD  in  WIDTH  memory read data; valid 1 cycle after MEM_ADDR is presented.
- MEM_ADDR  out  ADDR_W  memory word address.
- MEM_WE  out  1  memory write enable.
- MEM_WD  out  WIDTH  memory write data.
- VD_OUT  out  [LANES-1:0][WIDTH-1:0]  assembled load vector, to bank WD3.
- WE3  out  1  bank write enable, 1-cycle pulse.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  1-cycle completion pulse.

Behaviour:
- Reset (async, any state): FSM -> IDLE; lane counter = 0; VD_OUT = 0; MEM_ADDR = 0; MEM_WD = 0; MEM_WE = 0; WE3 = 0; BUSY = 0; DONE = 0.
  - Any partially loaded vector is discarded. No WE3 or MEM_WE is issued afterwards.
- States: IDLE, LOAD, LOAD_LAST, WRITEBACK, STORE, FINISH.
- IDLE:
  - START = 1 latches OP, BASE_ADDR and VS (store only), clears counter i, and moves to LOAD (OP = 0) or STORE (OP = 1).
  - START while BUSY is ignored.
- LOAD (i = 0..LANES-1, one cycle each):
  - MEM_ADDR = BASE + i, MEM_WE = 0.
  - For i >= 1, capture MEM_RD into lane i-1 of the internal buffer.
  - After i = LANES-1, go to LOAD_LAST.
- LOAD_LAST: capture MEM_RD into lane LANES-1; go to WRITEBACK.
- WRITEBACK:
  - WE3 = 1 and DONE = 1 for exactly this cycle.
  - VD_OUT holds the complete vector and remains stable until the next load reaches WRITEBACK.
  - Next state IDLE.
- VD_OUT changes only on entry to WRITEBACK; the buffer is internal. The bank therefore never sees a partially assembled vector.
- STORE (i = 0..LANES-1):
  - MEM_ADDR = BASE + i, MEM_WD = latched VS[i], MEM_WE = 1.
  - After i = LANES-1, go to FINISH.
- FINISH: MEM_WE = 0, DONE = 1 for one cycle; next state IDLE. WE3 stays 0 for stores.
- Latency, counted from the START-accepting edge to DONE high:
  - load: LANES + 2 cycles (12 at default);
  - store: LANES + 1 cycles (11 at default).
- Back-to-back: START asserted during the DONE cycle is not accepted. The earliest accept is the first IDLE cycle after DONE.
- Address arithmetic is modulo 2^ADDR_W: BASE = 0xFFFE yields 0xFFFE, 0xFFFF, 0x0000 ... 0x0007. No error flag.
- Outputs are registered. MEM_ADDR holds its last value when idle. MEM_WE is 0 outside STORE.
- VS is sampled only at START. Later changes to VS do not affect an in-progress store.

Test Plan:
- Reset then idle: RST pulse, no START -> all outputs 0, BUSY = 0 for 5 cycles, no MEM_WE/WE3.
- Load: memory[100+k] = 11*k, START, OP = 0, BASE = 100 -> MEM_ADDR walks 100..109; DONE and WE3 high together for one cycle, 12 cycles after accept; VD_OUT = {99, 88, ..., 11, 0} (lane 9..0); WE3 then 0.
- Store: VS lanes = 0..9 x 0x0101, START, OP = 1, BASE = 0x0200 -> MEM_WE high for exactly 10 cycles; (MEM_ADDR, MEM_WD) = (0x0200 + k, 0x0101*k); DONE at cycle 11; WE3 never asserted.
- Wrap: load with BASE = 0xFFFC -> addresses 0xFFFC..0xFFFF, 0x0000..0x0005; lanes match those words.
- Busy / START interaction: START held high throughout a load -> exactly one transfer per IDLE visit; START re-pulsed mid-load is ignored; VS changed mid-store does not alter MEM_WD.
- Reset mid-operation: assert RST at the 5th LOAD cycle -> immediate IDLE with outputs 0; no WE3 or DONE follows; next load completes correctly.
